crank_wheel_gen: RTL and testbench

Synthesizable crank trigger-wheel generator producing the digital tooth waveform that the `sync` decoder consumes on its `vrin` input, e.g. 60-2 or 36-1. It sits in the stim/self-test path of the EFI fabric: on the bench it drives `sync` directly, and in hardware it drives a loopback/ECU-simulator output pin. Tooth count, missing-tooth count and tooth period are runtime inputs, applied only at revolution boundaries so the emitted pattern is always self-consistent.

---
 rtl/crank_wheel_gen.sv | 154 +++++++++++++++
 tb/tb_crank_wheel_gen.sv | 228 ++++++++++++++++++++++
 2 files changed

// File: rtl/crank_wheel_gen.sv
`default_nettype none
// ============================================================================
// Module   : crank_wheel_gen
// Purpose  : Crank trigger-wheel (N-M) tooth waveform generator for sync/ECU
//            loopback stimulus; config applied only at revolution boundaries.
// Revision : 1.0 - initial release
// ============================================================================
module crank_wheel_gen #(
  parameter int TOOTH_W = 8,
  parameter int PER_W   = 24
) (
  input  logic               clk,
  input  logic               reset_n,
  input  logic               en,
  input  logic [TOOTH_W-1:0] total_teeth,
  input  logic [TOOTH_W-1:0] missing_teeth,
  input  logic [PER_W-1:0]   tooth_period,
  output logic               vr_out,
  output logic [TOOTH_W-1:0] tooth_index,
  output logic               in_gap,
  output logic               rev_strobe,
  output logic               running,
  output logic               cfg_err
);

  typedef enum logic [0:0] {
    ST_IDLE = 1'b0,
    ST_RUN  = 1'b1
  } state_t;

  localparam logic [TOOTH_W-1:0] C_N_MIN = TOOTH_W'(2);
  localparam logic [PER_W-1:0]   C_P_MIN = PER_W'(2);
  localparam logic [TOOTH_W-1:0] C_T_ONE = TOOTH_W'(1);
  localparam logic [PER_W-1:0]   C_P_ONE = PER_W'(1);

  state_t               r_state, w_state_nx;
  logic [PER_W-1:0]     r_ph, w_ph_nx;
  logic [TOOTH_W-1:0]   r_t, w_t_nx;
  logic [TOOTH_W-1:0]   r_n, w_n_nx;
  logic [TOOTH_W-1:0]   r_m, w_m_nx;
  logic [PER_W-1:0]     r_p, w_p_nx;
  logic                 r_cfg_err, w_cfg_err_nx;

  logic                 r_vr, r_gap, r_rev, r_run;
  logic [TOOTH_W-1:0]   r_idx;

  logic                 w_cfg_ok;
  logic [PER_W-1:0]     w_p_clamp;
  logic                 w_run_nx;
  logic                 w_present_nx;

  assign w_cfg_ok  = (total_teeth >= C_N_MIN) && (missing_teeth < total_teeth);
  assign w_p_clamp = (tooth_period < C_P_MIN) ? C_P_MIN : tooth_period;

  always_comb begin
    w_state_nx   = r_state;
    w_ph_nx      = r_ph;
    w_t_nx       = r_t;
    w_n_nx       = r_n;
    w_m_nx       = r_m;
    w_p_nx       = r_p;
    w_cfg_err_nx = r_cfg_err;
    case (r_state)
      ST_IDLE: begin
        w_ph_nx = '0;
        w_t_nx  = '0;
        if (en) begin
          if (w_cfg_ok) begin
            w_state_nx   = ST_RUN;
            w_n_nx       = total_teeth;
            w_m_nx       = missing_teeth;
            w_p_nx       = w_p_clamp;
            w_cfg_err_nx = 1'b0;
          end else begin
            w_cfg_err_nx = 1'b1;
          end
        end
      end
      ST_RUN: begin
        if (!en) begin
          w_state_nx = ST_IDLE;
          w_ph_nx    = '0;
          w_t_nx     = '0;
        end else if (r_ph == r_p - C_P_ONE) begin
          w_ph_nx = '0;
          if (r_t == r_n - C_T_ONE) begin
            // Revolution boundary: the only point where new config takes effect
            w_t_nx = '0;
            if (w_cfg_ok) begin
              w_n_nx = total_teeth;
              w_m_nx = missing_teeth;
              w_p_nx = w_p_clamp;
            end else begin
              w_state_nx   = ST_IDLE;
              w_cfg_err_nx = 1'b1;
            end
          end else begin
            w_t_nx = r_t + C_T_ONE;
          end
        end else begin
          w_ph_nx = r_ph + C_P_ONE;
        end
      end
      default: begin
        w_state_nx = ST_IDLE;
        w_ph_nx    = '0;
        w_t_nx     = '0;
      end
    endcase
  end

  // Outputs are decoded from next-state values so they register alongside it
  assign w_run_nx     = (w_state_nx == ST_RUN);
  assign w_present_nx = w_t_nx < (w_n_nx - w_m_nx);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state   <= ST_IDLE;
      r_ph      <= '0;
      r_t       <= '0;
      r_n       <= '0;
      r_m       <= '0;
      r_p       <= '0;
      r_cfg_err <= 1'b0;
      r_vr      <= 1'b0;
      r_gap     <= 1'b0;
      r_rev     <= 1'b0;
      r_run     <= 1'b0;
      r_idx     <= '0;
    end else begin
      r_state   <= w_state_nx;
      r_ph      <= w_ph_nx;
      r_t       <= w_t_nx;
      r_n       <= w_n_nx;
      r_m       <= w_m_nx;
      r_p       <= w_p_nx;
      r_cfg_err <= w_cfg_err_nx;
      r_vr      <= w_run_nx && w_present_nx && (w_ph_nx < (w_p_nx >> 1));
      r_gap     <= w_run_nx && !w_present_nx;
      r_rev     <= w_run_nx && (w_t_nx == '0) && (w_ph_nx == '0);
      r_run     <= w_run_nx;
      r_idx     <= w_run_nx ? w_t_nx : '0;
    end
  end

  assign vr_out      = r_vr;
  assign tooth_index = r_idx;
  assign in_gap      = r_gap;
  assign rev_strobe  = r_rev;
  assign running     = r_run;
  assign cfg_err     = r_cfg_err;

endmodule
`default_nettype wire

// File: tb/tb_crank_wheel_gen.sv
`default_nettype none
// ============================================================================
// Module   : tb_crank_wheel_gen
// Purpose  : Scoreboard bench for crank_wheel_gen with directed wheel configs.
// Revision : 1.0 - initial release
// ============================================================================
module tb_crank_wheel_gen;

  typedef struct packed {
    logic       vr;
    logic [7:0] idx;
    logic       gap;
    logic       rev;
    logic       run;
    logic       err;
  } exp_t;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        en = 1'b0;
  logic [7:0]  total_teeth = '0;
  logic [7:0]  missing_teeth = '0;
  logic [23:0] tooth_period = '0;
  logic        vr_out, in_gap, rev_strobe, running, cfg_err;
  logic [7:0]  tooth_index;

  int checks = 0;
  int failures = 0;
  exp_t q[$];
  int rev_times[$];
  int cyc = 0;
  logic meas = 1'b0;
  int m_hi, m_gap, m_rev, m_low_run, m_max_low, m_hi_run, m_max_hi;

  crank_wheel_gen #(.TOOTH_W(8), .PER_W(24)) dut (
    .clk(clk), .reset_n(reset_n), .en(en),
    .total_teeth(total_teeth), .missing_teeth(missing_teeth),
    .tooth_period(tooth_period),
    .vr_out(vr_out), .tooth_index(tooth_index), .in_gap(in_gap),
    .rev_strobe(rev_strobe), .running(running), .cfg_err(cfg_err)
  );

  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: run did not complete in time");
    $fatal(1, "watchdog");
  end

  // Monitor: every cycle with a pending expectation is compared
  initial begin
    exp_t e, a;
    forever begin
      @(posedge clk);
      #1;
      cyc++;
      if (rev_strobe) rev_times.push_back(cyc);
      if (meas) begin
        m_hi  += int'(vr_out);
        m_gap += int'(in_gap);
        m_rev += int'(rev_strobe);
        if (vr_out) begin
          m_low_run = 0; m_hi_run++;
          if (m_hi_run > m_max_hi) m_max_hi = m_hi_run;
        end else begin
          m_hi_run = 0; m_low_run++;
          if (m_low_run > m_max_low) m_max_low = m_low_run;
        end
      end
      if (q.size() > 0) begin
        e = q.pop_front();
        a = '{vr_out, tooth_index, in_gap, rev_strobe, running, cfg_err};
        checks++;
        if (a !== e) begin
          failures++;
          $display("FAIL outputs cyc=%0d got vr=%b idx=%0d gap=%b rev=%b run=%b err=%b exp vr=%b idx=%0d gap=%b rev=%b run=%b err=%b",
                   cyc, a.vr, a.idx, a.gap, a.rev, a.run, a.err,
                   e.vr, e.idx, e.gap, e.rev, e.run, e.err);
        end
      end
    end
  end

  task automatic check_int(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s got=%0d exp=%0d", name, act, exp);
    end
  endtask

  task automatic check_zero(input string name);
    check_int(name, int'({vr_out, tooth_index, in_gap, rev_strobe, running, cfg_err}), 0);
  endtask

  task automatic idle(input logic err, input int cnt);
    for (int i = 0; i < cnt; i++) begin
      q.push_back('{1'b0, 8'd0, 1'b0, 1'b0, 1'b0, err});
      @(negedge clk);
    end
  endtask

  // Expected RUN outputs from wheel geometry: teeth below N-M present, high for P/2
  task automatic run(input int n, input int m, input int p, input int t0, input int ph0, input int cnt);
    int t, ph;
    exp_t e;
    t = t0; ph = ph0;
    for (int i = 0; i < cnt; i++) begin
      e.vr  = (t < n - m) && (ph < p / 2);
      e.idx = 8'(t);
      e.gap = (t >= n - m);
      e.rev = (t == 0) && (ph == 0);
      e.run = 1'b1;
      e.err = 1'b0;
      q.push_back(e);
      @(negedge clk);
      ph++;
      if (ph == p) begin
        ph = 0; t++;
        if (t == n) t = 0;
      end
    end
  endtask

  task automatic meas_start();
    m_hi = 0; m_gap = 0; m_rev = 0;
    m_low_run = 0; m_max_low = 0; m_hi_run = 0; m_max_hi = 0;
    meas = 1'b1;
  endtask

  task automatic set_cfg(input int n, input int m, input int p);
    total_teeth = 8'(n); missing_teeth = 8'(m); tooth_period = 24'(p);
  endtask

  initial begin
    #1;
    check_zero("reset_state");
    @(negedge clk);
    reset_n = 1'b1;
    idle(1'b0, 3);

    // Invalid config, then accepted on the next cycle
    set_cfg(4, 4, 6); en = 1'b1;
    idle(1'b1, 3);
    missing_teeth = 8'd1;
    run(4, 1, 6, 0, 0, 24);
    missing_teeth = 8'd5;           // rejected at the revolution boundary
    idle(1'b1, 2);
    set_cfg(1, 0, 6);
    idle(1'b1, 1);
    en = 1'b0;
    idle(1'b1, 2);

    // 60-2 baseline, two revolutions; measure the second
    set_cfg(60, 2, 10); en = 1'b1;
    run(60, 2, 10, 0, 0, 600);
    meas_start();
    run(60, 2, 10, 0, 0, 600);
    meas = 1'b0;
    check_int("base_hi_clocks", m_hi, 290);
    check_int("base_gap_clocks", m_gap, 20);
    check_int("base_rev_count", m_rev, 1);
    check_int("base_max_low", m_max_low, 25);
    check_int("base_max_high", m_max_hi, 5);
    check_int("base_rev_period", rev_times[$] - rev_times[$-1], 600);

    // 36-1 at P=8, period change at tooth 10 waits for the wrap
    set_cfg(36, 1, 8);
    run(36, 1, 8, 0, 0, 80);
    tooth_period = 24'd20;
    run(36, 1, 8, 10, 0, 208);
    run(36, 1, 20, 0, 0, 720);
    check_int("chg_rev_p8", rev_times[$] - rev_times[$-1], 288);

    // Period edge cases and M=0
    set_cfg(4, 1, 3);
    run(4, 1, 3, 0, 0, 12);
    set_cfg(4, 1, 0);
    run(4, 1, 2, 0, 0, 8);
    set_cfg(4, 1, 1);
    run(4, 1, 2, 0, 0, 8);
    set_cfg(3, 0, 4);
    meas_start();
    run(3, 0, 4, 0, 0, 24);
    meas = 1'b0;
    check_int("m0_gap_clocks", m_gap, 0);
    check_int("m0_hi_clocks", m_hi, 12);

    // Stop mid high phase
    set_cfg(5, 1, 10);
    run(5, 1, 10, 0, 0, 12);
    en = 1'b0;
    idle(1'b0, 2);

    // Reset mid-tooth
    en = 1'b1;
    run(5, 1, 10, 0, 0, 13);
    reset_n = 1'b0;
    #1;
    check_zero("reset_mid_tooth");
    @(negedge clk);
    en = 1'b0; reset_n = 1'b1;
    idle(1'b0, 2);

    // Reset clears a latched cfg_err
    set_cfg(3, 3, 4); en = 1'b1;
    idle(1'b1, 2);
    reset_n = 1'b0;
    #1;
    check_zero("reset_clears_err");
    @(negedge clk);
    en = 1'b0; reset_n = 1'b1;
    idle(1'b0, 2);

    // Restart after reset begins at tooth 0, phase 0
    set_cfg(5, 1, 10); en = 1'b1;
    run(5, 1, 10, 0, 0, 50);
    en = 1'b0;
    idle(1'b0, 1);

    check_int("queue_drained", q.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
